// File: rtl/renkon_pkg.sv
// rtl/renkon_pkg.sv - shared widths, write-back state encoding and latency constant
package renkon_pkg;
  localparam int WB_CORE = 8;
  localparam int LWIDTH  = 6;
  localparam int DWIDTH  = 8;
  localparam int D_WB    = WB_CORE + 1;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } wb_state_t;
endpackage

// File: rtl/renkon_ctrl_bus.sv
// rtl/renkon_ctrl_bus.sv - stage-to-stage start/valid/stop/delay handshake bundle
interface ctrl_bus;
  logic                          start;
  logic                          valid;
  logic                          stop;
  logic                          ready;
  logic [renkon_pkg::DWIDTH-1:0] delay;

  modport master (output start, output valid, output stop, output delay);
  modport slave  (input start, input valid, input stop, input delay, output ready);
endinterface

// File: rtl/renkon_wb_serial.sv
// rtl/renkon_wb_serial.sv - walks one pixel's lanes onto the write port, one per cycle
module renkon_wb_serial #(
  parameter int CORE   = 8,
  parameter int OWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     kick,
  input  logic [OWIDTH-1:0]        base,
  input  logic [OWIDTH-1:0]        map_size,
  input  logic [OWIDTH-1:0]        pix,
  output logic                     we,
  output logic [$clog2(CORE)-1:0]  lane,
  output logic [OWIDTH-1:0]        addr,
  output logic                     idle
);
  localparam int LW = $clog2(CORE);
  localparam logic [LW-1:0] LAST = LW'(CORE - 1);

  // A kick always restarts at lane 0, which both chains pixels and drops an unfinished one.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      we   <= 1'b0;
      lane <= '0;
      addr <= '0;
    end else if (kick) begin
      we   <= 1'b1;
      lane <= '0;
      addr <= base + pix;
    end else if (we) begin
      if (lane == LAST) begin
        we   <= 1'b0;
        lane <= '0;
        addr <= '0;
      end else begin
        lane <= lane + LW'(1);
        addr <= addr + map_size;
      end
    end
  end

  assign idle = !we;
endmodule

// File: rtl/renkon_ctrl_wb.sv
// rtl/renkon_ctrl_wb.sv - pooled-pixel write-back controller; RENKON_CTRL_WB_ERR_EN adds wb_err
module renkon_ctrl_wb
  import renkon_pkg::*;
#(
  parameter int CORE   = WB_CORE,
  parameter int OWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     _wb_en,
  ctrl_bus.slave                   in_ctrl,
  input  logic [LWIDTH-1:0]        _out_size,
  input  logic [OWIDTH-1:0]        _out_base,
  ctrl_bus.master                  out_ctrl,
  output logic                     wb_latch,
  output logic [$clog2(CORE)-1:0]  mem_lane,
  output logic                     mem_we,
  output logic [OWIDTH-1:0]        mem_addr
`ifdef RENKON_CTRL_WB_ERR_EN
 ,output logic                     wb_err
`endif
);
  localparam int LW = $clog2(CORE);

  logic [1:0]          state;
  logic [OWIDTH-1:0]   base_r;
  logic [OWIDTH-1:0]   map_size;
  logic [OWIDTH-1:0]   pix;
  logic [OWIDTH-1:0]   pix_nxt;
  logic [2*LWIDTH-1:0] size_sq;
  logic                start_acc;
  logic                kick;
  logic                idle;
  logic                overflow;
  logic                stop_pulse;
  logic                start_q;
  logic                valid_q;
  logic                stop_q;
  logic [DWIDTH-1:0]   delay_q;

  assign start_acc = in_ctrl.start && (state == S_WAIT);
  assign kick      = _wb_en && in_ctrl.valid && (state != S_WAIT);
  assign wb_latch  = kick;
  assign overflow  = kick && mem_we && (mem_lane != LW'(CORE - 1));
  assign size_sq   = {{LWIDTH{1'b0}}, _out_size} * {{LWIDTH{1'b0}}, _out_size};
  assign pix_nxt   = pix + OWIDTH'(1);

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state      <= S_WAIT;
      base_r     <= '0;
      map_size   <= '0;
      pix        <= '0;
      stop_pulse <= 1'b0;
    end else begin
      stop_pulse <= 1'b0;
      case (state)
        S_WAIT: if (in_ctrl.start) begin
          state    <= S_ACTIVE;
          base_r   <= _out_base;
          map_size <= OWIDTH'(size_sq);
          pix      <= '0;
        end
        S_ACTIVE: if (in_ctrl.stop) state <= S_DRAIN;
        // A valid arriving with the stop still has to be serialised before completion.
        S_DRAIN: if (idle && !kick) begin
          state      <= S_WAIT;
          stop_pulse <= 1'b1;
        end
        default: state <= S_WAIT;
      endcase
      if (kick) pix <= (pix_nxt == map_size) ? '0 : pix_nxt;
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      stop_q  <= 1'b0;
      delay_q <= '0;
    end else begin
      start_q <= _wb_en ? start_acc : in_ctrl.start;
      valid_q <= in_ctrl.valid;
      stop_q  <= in_ctrl.stop;
      delay_q <= _wb_en ? in_ctrl.delay + DWIDTH'(CORE + 1) : in_ctrl.delay;
    end
  end

  renkon_wb_serial #(
    .CORE   (CORE),
    .OWIDTH (OWIDTH)
  ) u_serial (
    .clk      (clk),
    .xrst     (xrst),
    .kick     (kick),
    .base     (base_r),
    .map_size (map_size),
    .pix      (pix),
    .we       (mem_we),
    .lane     (mem_lane),
    .addr     (mem_addr),
    .idle     (idle)
  );

  assign in_ctrl.ready  = (state == S_WAIT);
  assign out_ctrl.start = start_q;
  assign out_ctrl.valid = _wb_en ? mem_we : valid_q;
  assign out_ctrl.stop  = _wb_en ? stop_pulse : stop_q;
  assign out_ctrl.delay = delay_q;

`ifdef RENKON_CTRL_WB_ERR_EN
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst)           wb_err <= 1'b0;
    else if (start_acc) wb_err <= 1'b0;
    else if (overflow)  wb_err <= 1'b1;
  end
`endif
endmodule
